// File: rtl/fft_cfg_pkg.sv
// Shared definitions for the FFT configuration sequencer: state encoding,
// config-word field offsets and the byte-rounded word width.
package fft_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } seqState_t;

    localparam int unsigned NFFT_OFF = 0;
    localparam int unsigned DIR_OFF  = 8;

    // Byte-aligned width holding the size byte, direction bits and schedule.
    function automatic int unsigned cfg_width(input int unsigned ch, input int unsigned sw);
        return 8 * ((8 + ch + sw + 7) / 8);
    endfunction

endpackage

// File: rtl/fft_cfg_pack.sv
// Packs frame size, per-channel direction and scaling schedule into one
// byte-aligned FFT config word; unused MSBs are zero.
module fft_cfg_pack
    import fft_cfg_pkg::*;
#(
    parameter int unsigned CHANNELS = 1,
    parameter int unsigned NFFT_W   = 5,
    parameter int unsigned SCALE_W  = 12,
    parameter int unsigned CFG_W    = cfg_width(CHANNELS, SCALE_W)
) (
    input  logic [NFFT_W-1:0]   frameSize,
    input  logic [CHANNELS-1:0] inverse,
    input  logic [SCALE_W-1:0]  scaleSch,
    output logic [CFG_W-1:0]    cfgWord_c
);

    localparam int unsigned SCH_OFF = DIR_OFF + CHANNELS;

    always_comb begin
        cfgWord_c                       = '0;
        cfgWord_c[NFFT_OFF +: 8]        = 8'(frameSize);
        cfgWord_c[DIR_OFF +: CHANNELS]  = inverse;
        cfgWord_c[SCH_OFF +: SCALE_W]   = scaleSch;
    end

endmodule

// File: rtl/fft_config_sequencer.sv
// Watches frame size, direction and scaling inputs and delivers each change
// to the FFT core's AXI4-Stream config slave, with size checking and a holdoff.
module fft_config_sequencer
    import fft_cfg_pkg::*;
#(
    parameter  int unsigned CHANNELS = 1,
    parameter  int unsigned NFFT_W   = 5,
    parameter  int unsigned MIN_NFFT = 3,
    parameter  int unsigned MAX_NFFT = 11,
    parameter  int unsigned SCALE_W  = 12,
    parameter  int unsigned HOLDOFF  = 4,
    localparam int unsigned CFG_W    = cfg_width(CHANNELS, SCALE_W)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NFFT_W-1:0]   frameSize,
    input  logic [CHANNELS-1:0] inverse,
    input  logic [SCALE_W-1:0]  scaleSch,
    input  logic                cfgReq,
    output logic [CFG_W-1:0]    tData,
    output logic                tValid,
    input  logic                tReady,
    output logic                cfgDone,
    output logic                badSize,
    output logic                busy
);

    localparam int unsigned FLD_W = NFFT_W + CHANNELS + SCALE_W;

    seqState_t        state;
    logic [FLD_W-1:0] shadow;
    logic             pend;
    logic [7:0]       gapCnt;
    logic [FLD_W-1:0] fields;
    logic [CFG_W-1:0] packedWord;
    logic             sizeOk;
    logic             pendSet;

    fft_cfg_pack #(
        .CHANNELS (CHANNELS),
        .NFFT_W   (NFFT_W),
        .SCALE_W  (SCALE_W),
        .CFG_W    (CFG_W)
    ) u_pack (
        .frameSize (frameSize),
        .inverse   (inverse),
        .scaleSch  (scaleSch),
        .cfgWord_c (packedWord)
    );

    assign fields  = {frameSize, inverse, scaleSch};
    assign sizeOk  = (frameSize >= NFFT_W'(MIN_NFFT)) && (frameSize <= NFFT_W'(MAX_NFFT));
    assign pendSet = pend || (fields != shadow) || cfgReq;

    // Launch also requires the live size to be legal so an illegal size
    // present at reset release never slips out before badSize registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            shadow  <= '0;
            pend    <= 1'b1;
            gapCnt  <= '0;
            tData   <= '0;
            tValid  <= 1'b0;
            cfgDone <= 1'b0;
            badSize <= 1'b0;
            busy    <= 1'b0;
        end else begin
            cfgDone <= 1'b0;
            badSize <= !sizeOk;
            case (state)
                IDLE: begin
                    if (pend && !badSize && sizeOk) begin
                        tData  <= packedWord;
                        tValid <= 1'b1;
                        shadow <= fields;
                        pend   <= cfgReq;
                        state  <= SEND;
                        busy   <= 1'b1;
                    end else begin
                        pend <= pendSet;
                        busy <= pendSet;
                    end
                end
                SEND: begin
                    pend <= pendSet;
                    if (tReady) begin
                        tValid  <= 1'b0;
                        cfgDone <= 1'b1;
                        gapCnt  <= 8'(HOLDOFF);
                        if (HOLDOFF == 0) begin
                            state <= IDLE;
                            busy  <= pendSet;
                        end else begin
                            state <= GAP;
                            busy  <= 1'b1;
                        end
                    end else begin
                        busy <= 1'b1;
                    end
                end
                GAP: begin
                    pend <= pendSet;
                    if (gapCnt <= 8'd1) begin
                        state <= IDLE;
                        busy  <= pendSet;
                    end else begin
                        gapCnt <= gapCnt - 8'd1;
                        busy   <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= pendSet;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_config_sequencer.sv
// Randomised bench for fft_config_sequencer with a word-level reference model
// and a negedge monitor recording every accepted config word.
module tb_fft_config_sequencer;

    localparam int HOLD = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic [4:0]  frameSize;
    logic [0:0]  inverse;
    logic [11:0] scaleSch;
    logic        cfgReq;
    logic        tReady;
    logic [23:0] tData;
    logic        tValid;
    logic        cfgDone;
    logic        badSize;
    logic        busy;

    logic [4:0]  pkFs;
    logic [1:0]  pkInv;
    logic [13:0] pkSch;
    logic [23:0] pkWord;

    int total = 0;
    int bad   = 0;

    logic [23:0] accQ[$];
    bit          seen[logic [23:0]];
    int          doneCnt = 0, stabViol = 0, gapViol = 0, badViol = 0;
    int          illegalCnt = 0, unknownCnt = 0, lastGap = 0, lowCnt = 0;
    bit          prevStall = 1'b0, sinceHs = 1'b0, fsKnown = 1'b0, prevValid = 1'b0;
    logic [23:0] prevData;
    logic [4:0]  prevFs;

    fft_config_sequencer #(
        .CHANNELS (1),
        .NFFT_W   (5),
        .MIN_NFFT (3),
        .MAX_NFFT (11),
        .SCALE_W  (12),
        .HOLDOFF  (HOLD)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .frameSize (frameSize),
        .inverse   (inverse),
        .scaleSch  (scaleSch),
        .cfgReq    (cfgReq),
        .tData     (tData),
        .tValid    (tValid),
        .tReady    (tReady),
        .cfgDone   (cfgDone),
        .badSize   (badSize),
        .busy      (busy)
    );

    fft_cfg_pack #(
        .CHANNELS (2),
        .NFFT_W   (5),
        .SCALE_W  (14),
        .CFG_W    (24)
    ) pack2 (
        .frameSize (pkFs),
        .inverse   (pkInv),
        .scaleSch  (pkSch),
        .cfgWord_c (pkWord)
    );

    always #5 CLK = ~CLK;

    // Word model: size byte, then direction bits, then schedule, LSB first.
    function automatic logic [23:0] refWord(input int fs, input int inv, input int sch);
        return 24'(fs + inv * 256 + sch * 512);
    endfunction

    function automatic logic [23:0] refWord2(input int fs, input int inv, input int sch);
        return 24'(fs + inv * 256 + sch * 1024);
    endfunction

    // Records handshakes and protocol-rule violations observed on the bus.
    always @(negedge CLK) begin
        if (RST) begin
            prevStall = 1'b0;
            sinceHs   = 1'b0;
            fsKnown   = 1'b0;
            prevValid = 1'b0;
        end else begin
            if (fsKnown && (badSize !== ((prevFs < 5'd3) || (prevFs > 5'd11)))) badViol++;
            if (prevStall && ((tValid !== 1'b1) || (tData !== prevData))) stabViol++;
            if (cfgDone === 1'b1) doneCnt++;
            if (tValid !== 1'b1) lowCnt++;
            else if (!prevValid && sinceHs) begin
                lastGap = lowCnt;
                if (lowCnt < HOLD) gapViol++;
            end
            if ((tValid === 1'b1) && (tReady === 1'b1)) begin
                accQ.push_back(tData);
                if ((tData[7:0] < 8'd3) || (tData[7:0] > 8'd11)) illegalCnt++;
                if (!seen.exists(tData)) unknownCnt++;
                sinceHs = 1'b1;
                lowCnt  = 0;
            end
            prevStall = (tValid === 1'b1) && (tReady !== 1'b1);
            prevData  = tData;
            prevValid = (tValid === 1'b1);
            fsKnown   = 1'b1;
        end
        prevFs = frameSize;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyCfg(input int fs, input int inv, input int sch);
        seen[refWord(fs, inv, sch)] = 1'b1;
        frameSize = 5'(fs);
        inverse   = 1'(inv);
        scaleSch  = 12'(sch);
    endtask

    task automatic waitIdle(input int target, output bit ok);
        ok = 1'b0;
        step();
        step();
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if ((accQ.size() >= target) && (busy === 1'b0) && (tValid === 1'b0)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic waitValid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (tValid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        logic [23:0] w;
        RST    = 1'b1;
        cfgReq = 1'b0;
        tReady = 1'b1;
        applyCfg(10, 0, 'hAAA);
        w = refWord(10, 0, 'hAAA);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        total++; if (tValid !== 1'b0)  begin bad++; $display("FAIL rst_tValid: got %b want 0", tValid); end
        total++; if (tData !== 24'h0)  begin bad++; $display("FAIL rst_tData: got %h want 000000", tData); end
        total++; if (cfgDone !== 1'b0) begin bad++; $display("FAIL rst_cfgDone: got %b want 0", cfgDone); end
        total++; if (badSize !== 1'b0) begin bad++; $display("FAIL rst_badSize: got %b want 0", badSize); end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        step();
        RST = 1'b0;
        waitIdle(1, ok);
        repeat (10) step();
        @(negedge CLK);
        total++; if (!ok) begin bad++; $display("FAIL rst_timeout: no idle after first word"); end
        total++; if (accQ.size() != 1) begin bad++; $display("FAIL rst_count: got %0d words want 1", accQ.size()); end
        total++; if (accQ[0] !== w) begin bad++; $display("FAIL rst_word: got %h want %h", accQ[0], w); end
        total++; if (doneCnt != 1) begin bad++; $display("FAIL rst_done: got %0d pulses want 1", doneCnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int n0, errs;
        logic [23:0] w10, w8;
        w10  = refWord(10, 0, 'hAAA);
        w8   = refWord(8, 0, 'hAAA);
        n0   = accQ.size();
        errs = 0;
        step();
        tReady = 1'b0;
        cfgReq = 1'b1;
        step();
        cfgReq = 1'b0;
        waitValid(ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_launch: tValid=%b want 1", tValid); end
        step();
        step();
        applyCfg(8, 0, 'hAAA);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if ((tValid !== 1'b1) || (tData !== w10)) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL bp_hold: %0d unstable cycles want 0", errs); end
        total++; if (tData !== w10) begin bad++; $display("FAIL bp_data: got %h want %h", tData, w10); end
        step();
        tReady = 1'b1;
        waitIdle(n0 + 2, ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_timeout: %0d words want %0d", accQ.size(), n0 + 2); end
        total++; if (accQ[n0] !== w10) begin bad++; $display("FAIL bp_word1: got %h want %h", accQ[n0], w10); end
        total++; if (accQ[n0+1] !== w8) begin bad++; $display("FAIL bp_word2: got %h want %h", accQ[n0+1], w8); end
        total++; if ((lastGap < HOLD) || (lastGap > HOLD + 2)) begin
            bad++; $display("FAIL bp_gap: got %0d idle cycles want %0d..%0d", lastGap, HOLD, HOLD + 2);
        end
    endtask

    task automatic test_badsize();
        bit ok;
        int n0;
        logic [23:0] w9;
        w9 = refWord(9, 0, 'hAAA);
        n0 = accQ.size();
        step();
        applyCfg(2, 0, 'hAAA);
        repeat (8) step();
        @(negedge CLK);
        total++; if (badSize !== 1'b1) begin bad++; $display("FAIL bad_low_flag: got %b want 1", badSize); end
        total++; if ((tValid !== 1'b0) || (accQ.size() != n0)) begin
            bad++; $display("FAIL bad_low_send: tValid=%b words=%0d want 0/%0d", tValid, accQ.size(), n0);
        end
        step();
        applyCfg(12, 0, 'hAAA);
        repeat (8) step();
        @(negedge CLK);
        total++; if (badSize !== 1'b1) begin bad++; $display("FAIL bad_high_flag: got %b want 1", badSize); end
        total++; if ((tValid !== 1'b0) || (accQ.size() != n0)) begin
            bad++; $display("FAIL bad_high_send: tValid=%b words=%0d want 0/%0d", tValid, accQ.size(), n0);
        end
        step();
        applyCfg(9, 0, 'hAAA);
        @(negedge CLK);
        @(negedge CLK);
        total++; if ((badSize !== 1'b0) || (tValid !== 1'b0)) begin
            bad++; $display("FAIL bad_clear: badSize=%b tValid=%b want 0/0", badSize, tValid);
        end
        @(negedge CLK);
        total++; if ((tValid !== 1'b1) || (tData !== w9)) begin
            bad++; $display("FAIL bad_latency: tValid=%b tData=%h want 1/%h", tValid, tData, w9);
        end
        waitIdle(n0 + 1, ok);
        total++; if (!ok) begin bad++; $display("FAIL bad_timeout: %0d words want %0d", accQ.size(), n0 + 1); end
        total++; if (accQ[n0] !== w9) begin bad++; $display("FAIL bad_word: got %h want %h", accQ[n0], w9); end
    endtask

    task automatic test_cfgreq();
        bit ok;
        int n0, n1;
        logic [23:0] w9;
        w9 = refWord(9, 0, 'hAAA);
        n0 = accQ.size();
        step();
        cfgReq = 1'b1;
        step();
        cfgReq = 1'b0;
        waitIdle(n0 + 1, ok);
        repeat (10) step();
        @(negedge CLK);
        total++; if (!ok || (accQ.size() != n0 + 1)) begin
            bad++; $display("FAIL req_count: got %0d words want %0d", accQ.size() - n0, 1);
        end
        total++; if (accQ[n0] !== w9) begin bad++; $display("FAIL req_word: got %h want %h", accQ[n0], w9); end
        n1 = accQ.size();
        step();
        tReady = 1'b0;
        cfgReq = 1'b1;
        step();
        cfgReq = 1'b0;
        waitValid(ok);
        total++; if (!ok) begin bad++; $display("FAIL req_launch: tValid=%b want 1", tValid); end
        step();
        tReady = 1'b1;
        cfgReq = 1'b1;
        step();
        cfgReq = 1'b0;
        waitIdle(n1 + 2, ok);
        repeat (10) step();
        @(negedge CLK);
        total++; if (!ok || (accQ.size() != n1 + 2)) begin
            bad++; $display("FAIL req_coincident: got %0d words want 2", accQ.size() - n1);
        end
        total++; if ((accQ[n1] !== w9) || (accQ[n1+1] !== w9)) begin
            bad++; $display("FAIL req_coincident_word: got %h %h want %h", accQ[n1], accQ[n1+1], w9);
        end
    endtask

    task automatic test_pack();
        logic [23:0] exp;
        int errs;
        pkFs  = 5'd6;
        pkInv = 2'b10;
        pkSch = 14'h1555;
        #1;
        exp = refWord2(6, 2, 'h1555);
        total++; if (pkWord !== exp) begin bad++; $display("FAIL pack_word: got %h want %h", pkWord, exp); end
        total++; if (pkWord[7:0] !== 8'h06) begin bad++; $display("FAIL pack_size: got %h want 06", pkWord[7:0]); end
        total++; if (pkWord[9:8] !== 2'b10) begin bad++; $display("FAIL pack_dir: got %b want 10", pkWord[9:8]); end
        total++; if (pkWord[23:10] !== 14'h1555) begin bad++; $display("FAIL pack_sch: got %h want 1555", pkWord[23:10]); end
        errs = 0;
        for (int i = 0; i < 8; i++) begin
            pkFs  = 5'($urandom_range(31));
            pkInv = 2'($urandom_range(3));
            pkSch = 14'($urandom_range(16383));
            #1;
            exp = refWord2(int'(pkFs), int'(pkInv), int'(pkSch));
            if (pkWord !== exp) begin
                errs++;
                $display("FAIL pack_rand: got %h want %h", pkWord, exp);
            end
        end
        total++; if (errs != 0) bad++;
    endtask

    task automatic test_reset_mid_send();
        bit ok;
        int n0;
        logic [23:0] w9;
        w9 = refWord(9, 0, 'hAAA);
        step();
        tReady = 1'b0;
        cfgReq = 1'b1;
        step();
        cfgReq = 1'b0;
        waitValid(ok);
        total++; if (!ok) begin bad++; $display("FAIL mid_launch: tValid=%b want 1", tValid); end
        step();
        #1;
        RST = 1'b1;
        #1;
        total++; if (tValid !== 1'b0) begin bad++; $display("FAIL mid_drop: tValid=%b want 0", tValid); end
        total++; if ((busy !== 1'b0) || (cfgDone !== 1'b0)) begin
            bad++; $display("FAIL mid_outputs: busy=%b cfgDone=%b want 0/0", busy, cfgDone);
        end
        n0 = accQ.size();
        step();
        step();
        RST    = 1'b0;
        tReady = 1'b1;
        waitIdle(n0 + 1, ok);
        total++; if (!ok || (accQ.size() != n0 + 1)) begin
            bad++; $display("FAIL mid_resend_count: got %0d words want 1", accQ.size() - n0);
        end
        total++; if (accQ[n0] !== w9) begin bad++; $display("FAIL mid_resend_word: got %h want %h", accQ[n0], w9); end
    endtask

    task automatic test_random();
        bit ok;
        int fs, inv, sch;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(7) == 0)
                applyCfg(int'($urandom_range(13, 1)), int'($urandom_range(1)), int'($urandom_range(4095)));
            cfgReq = ($urandom_range(15) == 0);
            tReady = 1'($urandom_range(1));
            step();
        end
        cfgReq = 1'b0;
        fs  = int'($urandom_range(11, 3));
        inv = int'($urandom_range(1));
        sch = int'($urandom_range(4095));
        applyCfg(fs, inv, sch);
        tReady = 1'b1;
        waitIdle(accQ.size(), ok);
        total++; if (!ok) begin bad++; $display("FAIL rnd_timeout: busy=%b tValid=%b", busy, tValid); end
        total++; if (accQ[$] !== refWord(fs, inv, sch)) begin
            bad++; $display("FAIL rnd_final: got %h want %h", accQ[$], refWord(fs, inv, sch));
        end
        total++; if (stabViol != 0) begin bad++; $display("FAIL rnd_stable: %0d violations want 0", stabViol); end
        total++; if (gapViol != 0) begin bad++; $display("FAIL rnd_gap: %0d violations want 0", gapViol); end
        total++; if (badViol != 0) begin bad++; $display("FAIL rnd_badsize: %0d violations want 0", badViol); end
        total++; if (illegalCnt != 0) begin bad++; $display("FAIL rnd_illegal: %0d illegal words want 0", illegalCnt); end
        total++; if (unknownCnt != 0) begin bad++; $display("FAIL rnd_unknown: %0d unpresented words want 0", unknownCnt); end
        total++; if (doneCnt != accQ.size()) begin
            bad++; $display("FAIL rnd_done: got %0d pulses want %0d", doneCnt, accQ.size());
        end
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_badsize();
        test_cfgreq();
        test_pack();
        test_reset_mid_send();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
